// File: rtl/enum_index_pkg.sv
// Shared constants and types for the enum-index table feeder and its selector queue.
package enum_index_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ENTRIES    = 4;
    localparam int unsigned SEL_W      = $clog2(ENTRIES);
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        ARMED
    } feeder_state_e;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/enum_index_table_feeder_if.sv
// Bundle of the table-write stream, selector request stream and downstream lookup outputs.
interface enum_index_table_feeder_if;
    import enum_index_pkg::*;

    logic                      ld_valid;
    logic                      ld_ready;
    sel_t                      ld_addr;
    logic [WORD_W-1:0]         ld_data;
    logic                      ld_last;
    logic                      req_valid;
    logic                      req_ready;
    sel_t                      req_sel;
    logic [ENTRIES*WORD_W-1:0] arr;
    sel_t                      sel;
    logic                      sel_valid;
    logic                      sel_ready;
    logic                      load_err;

    modport master (
        output ld_valid, ld_addr, ld_data, ld_last, req_valid, req_sel, sel_ready,
        input  ld_ready, req_ready, arr, sel, sel_valid, load_err
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last, req_valid, req_sel, sel_ready,
        output ld_ready, req_ready, arr, sel, sel_valid, load_err
    );

endinterface

// File: rtl/enum_index_sel_fifo.sv
// Synchronous FIFO with occupancy count; no pass-through, so a pop never frees a slot for a
// push in the same cycle.
module enum_index_sel_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [Width-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [Width-1:0]       rd_data,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic [Width-1:0] mem_q [Depth];
    logic             push, pop;

    assign full    = (count_q == (PtrW + 1)'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only entries below count are ever read as valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/enum_index_table_feeder.sv
// Loads a small lookup table over a write stream and issues queued selectors to the
// downstream combinational lookup, holding the table stable while a selector is presented.
module enum_index_table_feeder
    import enum_index_pkg::*;
(
    input logic                      clk,
    input logic                      rst,
    enum_index_table_feeder_if.slave bus
);

    feeder_state_e             state_q, state_d;
    logic [ENTRIES-1:0]        mask_q, mask_d, mask_set;
    logic [ENTRIES*WORD_W-1:0] arr_q, arr_d;
    sel_t                      sel_q, sel_d;
    logic                      sel_valid_q, sel_valid_d;
    logic                      load_err_q, load_err_d;

    logic                      ld_ready, ld_fire, issue;
    sel_t                      fifo_head;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full, fifo_empty;

    enum_index_sel_fifo #(
        .Width (SEL_W),
        .Depth (FIFO_DEPTH)
    ) u_sel_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.req_valid),
        .wr_data (bus.req_sel),
        .rd_en   (issue),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Reloading while armed is only allowed once nothing depends on the current table.
    always_comb begin
        ld_ready = 1'b0;
        unique case (state_q)
            EMPTY, LOADING: ld_ready = 1'b1;
            ARMED:          ld_ready = (fifo_count == '0) && !sel_valid_q;
            default:        ld_ready = 1'b0;
        endcase
    end

    assign ld_fire = bus.ld_valid && ld_ready;
    assign issue   = (state_q == ARMED) && (!sel_valid_q || bus.sel_ready) && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        arr_d      = arr_q;
        load_err_d = 1'b0;
        mask_set   = mask_q | (ENTRIES'(1) << bus.ld_addr);
        if (ld_fire) begin
            arr_d[bus.ld_addr*WORD_W +: WORD_W] = bus.ld_data;
            if (bus.ld_last) begin
                mask_d = '0;
                if (&mask_set) begin
                    state_d = ARMED;
                end else begin
                    state_d    = LOADING;
                    load_err_d = 1'b1;
                end
            end else begin
                mask_d  = mask_set;
                state_d = LOADING;
            end
        end
    end

    always_comb begin
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        if (issue) begin
            sel_d       = fifo_head;
            sel_valid_d = 1'b1;
        end else if (sel_valid_q && bus.sel_ready) begin
            sel_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            mask_q      <= '0;
            arr_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            arr_q       <= arr_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.ld_ready  = ld_ready;
    assign bus.req_ready = !fifo_full;
    assign bus.arr       = arr_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_enum_index_table_feeder.sv
// Directed bench for the table feeder: table-driven load and lookup vectors plus
// hand-written sequences for back-pressure, reload blocking, partial bursts and reset.
module tb_enum_index_table_feeder;
    import enum_index_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enum_index_table_feeder_if bus();

    enum_index_table_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        sel_t         addr;
        logic [31:0]  data;
        logic         last;
        logic [127:0] exp_arr;
        logic         exp_err;
    } ld_vec_t;

    typedef struct {
        sel_t        req;
        logic [31:0] exp_word;
    } rq_vec_t;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [127:0] exp_arr;
    ld_vec_t      lv [4];
    rq_vec_t      rv [4];
    sel_t         q4 [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] a, input sel_t i);
        return a[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted write beat; keeps the expected-table model in step.
    task automatic beat(input sel_t addr, input logic [31:0] data, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
        bus.ld_last  = last;
        check("ld_ready_beat", 128'(bus.ld_ready), 128'(1));
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        exp_arr[addr*32 +: 32] = data;
    endtask

    task automatic push_req(input sel_t s);
        bus.req_valid = 1'b1;
        bus.req_sel   = s;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        lv[0] = '{addr: 2'd0, data: 32'h11, last: 1'b0, exp_err: 1'b0,
                  exp_arr: 128'h00000000_00000000_00000000_00000011};
        lv[1] = '{addr: 2'd1, data: 32'h22, last: 1'b0, exp_err: 1'b0,
                  exp_arr: 128'h00000000_00000000_00000022_00000011};
        lv[2] = '{addr: 2'd2, data: 32'h33, last: 1'b0, exp_err: 1'b0,
                  exp_arr: 128'h00000000_00000033_00000022_00000011};
        lv[3] = '{addr: 2'd3, data: 32'h44, last: 1'b1, exp_err: 1'b0,
                  exp_arr: 128'h00000044_00000033_00000022_00000011};
        rv[0] = '{req: 2'd2, exp_word: 32'h33};
        rv[1] = '{req: 2'd0, exp_word: 32'h11};
        rv[2] = '{req: 2'd3, exp_word: 32'h44};
        rv[3] = '{req: 2'd1, exp_word: 32'h22};
        q4[0] = 2'd1; q4[1] = 2'd2; q4[2] = 2'd3; q4[3] = 2'd0; q4[4] = 2'd2;

        rst = 1'b1;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;
        bus.req_valid = 1'b0; bus.req_sel = '0; bus.sel_ready = 1'b0;
        exp_arr = '0;
        tick(); tick();
        check("rst_arr", bus.arr, 128'h0);
        check("rst_sel_valid", 128'(bus.sel_valid), 128'(0));
        check("rst_sel", 128'(bus.sel), 128'(0));
        check("rst_load_err", 128'(bus.load_err), 128'(0));
        check("rst_ld_ready", 128'(bus.ld_ready), 128'(1));
        check("rst_req_ready", 128'(bus.req_ready), 128'(1));
        rst = 1'b0;
        tick();

        // Full load, vector table.
        for (int i = 0; i < 4; i++) begin
            beat(lv[i].addr, lv[i].data, lv[i].last);
            check("load_arr", bus.arr, lv[i].exp_arr);
            check("load_err_full", 128'(bus.load_err), 128'(lv[i].exp_err));
        end
        tick();
        check("load_err_after", 128'(bus.load_err), 128'(0));

        // Single lookups: two-cycle latency from accept to sel_valid.
        bus.sel_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(rv[i].req);
            check("lat_n1_invalid", 128'(bus.sel_valid), 128'(0));
            tick();
            check("lat_n2_valid", 128'(bus.sel_valid), 128'(1));
            check("lat_sel", 128'(bus.sel), 128'(rv[i].req));
            check("lookup", 128'(word_of(bus.arr, bus.sel)), 128'(rv[i].exp_word));
            tick();
            check("consumed", 128'(bus.sel_valid), 128'(0));
        end

        // Back-pressure: one held in the output register, four queued, sixth refused.
        bus.sel_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_sel   = q4[i];
            check("bp_req_ready", 128'(bus.req_ready), 128'(1));
            tick();
        end
        bus.req_sel = 2'd3;
        check("bp_full", 128'(bus.req_ready), 128'(0));
        check("bp_head_valid", 128'(bus.sel_valid), 128'(1));
        check("bp_head", 128'(bus.sel), 128'(q4[0]));
        tick();
        bus.req_valid = 1'b0;
        check("bp_still_full", 128'(bus.req_ready), 128'(0));
        bus.sel_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 128'(bus.sel_valid), 128'(1));
            check("drain_sel", 128'(bus.sel), 128'(q4[i]));
            check("drain_lookup", 128'(word_of(bus.arr, bus.sel)),
                  128'(word_of(lv[3].exp_arr, q4[i])));
            tick();
        end
        check("drain_done", 128'(bus.sel_valid), 128'(0));

        // Reload attempt while a selector is pending is held off.
        bus.sel_ready = 1'b0;
        push_req(2'd3);
        push_req(2'd1);
        bus.ld_valid = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 32'hdeadbeef; bus.ld_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold_ld_ready", 128'(bus.ld_ready), 128'(0));
            check("hold_arr", bus.arr, exp_arr);
            tick();
        end
        bus.sel_ready = 1'b1;
        check("hold_sel_a", 128'(bus.sel), 128'(3));
        check("hold_ld_ready_a", 128'(bus.ld_ready), 128'(0));
        tick();
        check("hold_sel_b_valid", 128'(bus.sel_valid), 128'(1));
        check("hold_sel_b", 128'(bus.sel), 128'(1));
        check("hold_ld_ready_b", 128'(bus.ld_ready), 128'(0));
        check("hold_arr_b", bus.arr, exp_arr);
        tick();
        check("hold_released", 128'(bus.ld_ready), 128'(1));
        check("hold_arr_c", bus.arr, exp_arr);
        tick();
        bus.ld_valid = 1'b0;
        exp_arr[31:0] = 32'hdeadbeef;
        check("reload_arr", bus.arr, exp_arr);

        // Partial burst: entries 2,3 never written in this burst.
        beat(2'd0, 32'h55, 1'b0);
        check("part_err0", 128'(bus.load_err), 128'(0));
        beat(2'd1, 32'h66, 1'b0);
        check("part_err1", 128'(bus.load_err), 128'(0));
        beat(2'd1, 32'h77, 1'b1);
        check("part_err_pulse", 128'(bus.load_err), 128'(1));
        check("part_arr", bus.arr, 128'h00000044_00000033_00000077_00000055);
        tick();
        check("part_err_clear", 128'(bus.load_err), 128'(0));
        push_req(2'd0);
        for (int i = 0; i < 4; i++) begin
            check("part_no_issue", 128'(bus.sel_valid), 128'(0));
            tick();
        end

        // Complete burst; the queued request issues the cycle after arming.
        beat(2'd3, 32'ha3, 1'b0);
        beat(2'd2, 32'ha2, 1'b0);
        beat(2'd1, 32'ha1, 1'b0);
        beat(2'd0, 32'ha0, 1'b1);
        check("arm_err", 128'(bus.load_err), 128'(0));
        check("arm_not_yet", 128'(bus.sel_valid), 128'(0));
        tick();
        check("arm_issue_valid", 128'(bus.sel_valid), 128'(1));
        check("arm_issue_sel", 128'(bus.sel), 128'(0));
        check("arm_lookup", 128'(word_of(bus.arr, bus.sel)), 128'(32'ha0));
        tick();
        check("arm_consumed", 128'(bus.sel_valid), 128'(0));

        // Reset mid-burst with queued requests.
        bus.sel_ready = 1'b0;
        beat(2'd0, 32'h99, 1'b0);
        push_req(2'd1);
        push_req(2'd2);
        bus.ld_valid = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 32'h98; bus.ld_last = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mrst_arr", bus.arr, 128'h0);
        check("mrst_sel_valid", 128'(bus.sel_valid), 128'(0));
        check("mrst_req_ready", 128'(bus.req_ready), 128'(1));
        bus.ld_valid = 1'b0;
        tick();
        check("mrst_req_ready_edge", 128'(bus.req_ready), 128'(1));
        check("mrst_ld_ready_edge", 128'(bus.ld_ready), 128'(1));
        rst = 1'b0;
        exp_arr = '0;
        tick();
        bus.sel_ready = 1'b1;
        beat(2'd0, 32'h1, 1'b0);
        beat(2'd1, 32'h2, 1'b0);
        beat(2'd2, 32'h3, 1'b0);
        beat(2'd3, 32'h4, 1'b1);
        check("mrst_reload_arr", bus.arr, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) begin
            check("mrst_fifo_flushed", 128'(bus.sel_valid), 128'(0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
